// File: rtl/csr_file.sv
// Machine-mode CSR file: Zicsr read-modify-write, 64-bit cycle/instret counters,
// and trap entry / MRET updates of mstatus, mepc, mcause and mtval.
module csr_file #(
  parameter int              XLEN        = 32,
  parameter int              CNT_W       = 64,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000,
  parameter int              HART_ID     = 0,
  parameter logic [XLEN-1:0] MISA_VAL    = 32'h4000_0100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            csr_en,
  input  logic [2:0]      funct3,
  input  logic [11:0]     csr_addr,
  input  logic [4:0]      rs1_idx,
  input  logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rd_data,
  output logic            illegal,
  input  logic            instret_inc,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_val,
  input  logic            mret,
  output logic [XLEN-1:0] mtvec_out,
  output logic [XLEN-1:0] mepc_out,
  output logic            mie_out
);

  localparam logic [11:0] A_MSTATUS  = 12'h300, A_MISA     = 12'h301, A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340, A_MEPC     = 12'h341, A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343, A_MCYCLE   = 12'hB00, A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTRET = 12'hB02, A_MINSTRETH = 12'hB82, A_CYCLE   = 12'hC00;
  localparam logic [11:0] A_CYCLEH   = 12'hC80, A_INSTRET  = 12'hC02, A_INSTRETH = 12'hC82;
  localparam logic [11:0] A_MHARTID  = 12'hF14;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic            mie, mpie;
  logic [XLEN-1:0] mtvec, mepc, mscratch, mcause, mtval;
  logic [CNT_W-1:0] mcycle, minstret;

  logic [XLEN-1:0] old_val, src, new_val;
  logic            mapped, wr_req, we;

  // Counter halves assume CNT_W == 2*XLEN.
  always_comb begin
    mapped  = 1'b1;
    old_val = '0;
    case (csr_addr)
      A_MSTATUS:              old_val = XLEN'({2'b11, 3'b000, mpie, 3'b000, mie, 3'b000});
      A_MISA:                 old_val = MISA_VAL;
      A_MTVEC:                old_val = mtvec;
      A_MSCRATCH:             old_val = mscratch;
      A_MEPC:                 old_val = mepc;
      A_MCAUSE:               old_val = mcause;
      A_MTVAL:                old_val = mtval;
      A_MCYCLE,   A_CYCLE:    old_val = mcycle[XLEN-1:0];
      A_MCYCLEH,  A_CYCLEH:   old_val = mcycle[CNT_W-1:XLEN];
      A_MINSTRET, A_INSTRET:  old_val = minstret[XLEN-1:0];
      A_MINSTRETH, A_INSTRETH: old_val = minstret[CNT_W-1:XLEN];
      A_MHARTID:              old_val = XLEN'(HART_ID);
      default:                mapped  = 1'b0;
    endcase
  end

  always_comb begin
    src = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_idx} : rs1_data;
    case (funct3[1:0])
      2'b10:   new_val = old_val | src;
      2'b11:   new_val = old_val & ~src;
      default: new_val = src;
    endcase
  end

  // RS/RC with rs1 = x0 never writes, so it stays legal on read-only CSRs.
  assign wr_req  = csr_en && ((funct3[1:0] == 2'b01) || (rs1_idx != 5'd0));
  assign illegal = csr_en && (!mapped || (funct3[1:0] == 2'b00) ||
                              (wr_req && (csr_addr[11:10] == 2'b11)));
  assign we      = wr_req && !illegal && !trap_en && !mret;
  assign rd_data = (csr_en && !illegal) ? old_val : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= MTVEC_RESET;
      mepc     <= '0;
      mscratch <= '0;
      mcause   <= '0;
      mtval    <= '0;
    end else if (trap_en) begin
      mepc   <= trap_pc & ALIGN_MASK;
      mcause <= trap_cause;
      mtval  <= trap_val;
      mpie   <= mie;
      mie    <= 1'b0;
    end else if (mret) begin
      mie  <= mpie;
      mpie <= 1'b1;
    end else if (we) begin
      case (csr_addr)
        A_MSTATUS: begin
          mie  <= new_val[3];
          mpie <= new_val[7];
        end
        A_MTVEC:    mtvec    <= new_val & ALIGN_MASK;
        A_MEPC:     mepc     <= new_val & ALIGN_MASK;
        A_MSCRATCH: mscratch <= new_val;
        A_MCAUSE:   mcause   <= new_val;
        A_MTVAL:    mtval    <= new_val;
        default: ;
      endcase
    end
  end

  // A write to one half replaces only that half; no increment or carry that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (we && csr_addr == A_MCYCLE)       mcycle <= {mcycle[CNT_W-1:XLEN], new_val};
      else if (we && csr_addr == A_MCYCLEH) mcycle <= {new_val, mcycle[XLEN-1:0]};
      else                                  mcycle <= mcycle + CNT_W'(1);

      if (we && csr_addr == A_MINSTRET)       minstret <= {minstret[CNT_W-1:XLEN], new_val};
      else if (we && csr_addr == A_MINSTRETH) minstret <= {new_val, minstret[XLEN-1:0]};
      else                                    minstret <= minstret + CNT_W'(instret_inc);
    end
  end

  assign mtvec_out = mtvec;
  assign mepc_out  = mepc;
  assign mie_out   = mie;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: a vector table of CSR accesses plus hand-written
// sequences for counters, trap/MRET, carry/wrap and asynchronous reset.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csr_en = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [11:0] csr_addr = 12'h000;
  logic [4:0]  rs1_idx = 5'd0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rd_data;
  logic        illegal;
  logic        instret_inc = 1'b0;
  logic        trap_en = 1'b0;
  logic [31:0] trap_pc = '0, trap_cause = '0, trap_val = '0;
  logic        mret = 1'b0;
  logic [31:0] mtvec_out, mepc_out;
  logic        mie_out;

  int n_vec = 0;
  int n_err = 0;

  csr_file dut (
    .clk(clk), .rst_n(rst_n), .csr_en(csr_en), .funct3(funct3), .csr_addr(csr_addr),
    .rs1_idx(rs1_idx), .rs1_data(rs1_data), .rd_data(rd_data), .illegal(illegal),
    .instret_inc(instret_inc), .trap_en(trap_en), .trap_pc(trap_pc),
    .trap_cause(trap_cause), .trap_val(trap_val), .mret(mret),
    .mtvec_out(mtvec_out), .mepc_out(mepc_out), .mie_out(mie_out)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] RW = 3'b001, RS = 3'b010, RC = 3'b011;
  localparam logic [2:0] RWI = 3'b101, RSI = 3'b110, RCI = 3'b111;

  typedef struct {
    logic        en;
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [4:0]  idx;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [2:0] f3, input logic [11:0] addr,
                       input logic [4:0] idx, input logic [31:0] data);
    csr_en   = en;
    funct3   = f3;
    csr_addr = addr;
    rs1_idx  = idx;
    rs1_data = data;
  endtask

  // Read via CSRRS x0 on the next negedge and compare rd_data.
  task automatic read_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
    @(negedge clk);
    drive(1'b1, RS, addr, 5'd0, 32'h0);
    #1;
    check(name, rd_data, exp);
    check({name, "_ill"}, 32'(illegal), 32'd0);
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 12'h000, 5'd0, 32'h0);
  endtask

  initial begin
    vecs.push_back('{1, RS,  12'h305, 5'd0,  32'h0,        32'h0000_0000, 0});
    vecs.push_back('{1, RW,  12'h340, 5'd1,  32'hDEADBEEF, 32'h0000_0000, 0});
    vecs.push_back('{1, RC,  12'h340, 5'd2,  32'h0000FFFF, 32'hDEADBEEF, 0});
    vecs.push_back('{1, RS,  12'h340, 5'd0,  32'h0,        32'hDEAD0000, 0});
    vecs.push_back('{1, RWI, 12'hC00, 5'd5,  32'h0,        32'h0000_0000, 1});
    vecs.push_back('{1, RS,  12'hF14, 5'd0,  32'h0,        32'h0000_0000, 0});
    vecs.push_back('{1, RW,  12'h7FF, 5'd1,  32'h1,        32'h0000_0000, 1});
    vecs.push_back('{1, 3'b000, 12'h340, 5'd1, 32'h1,      32'h0000_0000, 1});
    vecs.push_back('{1, 3'b100, 12'h340, 5'd1, 32'h1,      32'h0000_0000, 1});
    vecs.push_back('{1, RW,  12'h301, 5'd1,  32'hFFFFFFFF, 32'h4000_0100, 0});
    vecs.push_back('{1, RS,  12'h301, 5'd0,  32'h0,        32'h4000_0100, 0});
    vecs.push_back('{1, RW,  12'h305, 5'd1,  32'h12345677, 32'h0000_0000, 0});
    vecs.push_back('{1, RS,  12'h305, 5'd0,  32'h0,        32'h1234_5674, 0});
    vecs.push_back('{1, RW,  12'hF14, 5'd1,  32'h5,        32'h0000_0000, 1});
    vecs.push_back('{1, RS,  12'h300, 5'd0,  32'h0,        32'h0000_1800, 0});
    vecs.push_back('{1, RSI, 12'h300, 5'd8,  32'h0,        32'h0000_1800, 0});
    vecs.push_back('{1, RS,  12'h300, 5'd0,  32'h0,        32'h0000_1808, 0});
    vecs.push_back('{1, RW,  12'h342, 5'd3,  32'hAAAA5555, 32'h0000_0000, 0});
    vecs.push_back('{1, RCI, 12'h342, 5'd31, 32'h0,        32'hAAAA5555, 0});
    vecs.push_back('{1, RS,  12'h342, 5'd0,  32'h0,        32'hAAAA5540, 0});
    vecs.push_back('{0, RS,  12'h340, 5'd0,  32'h0,        32'h0000_0000, 0});

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_mtvec", mtvec_out, 32'h0);
    check("rst_mepc", mepc_out, 32'h0);
    check("rst_mie", 32'(mie_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // mcycle counts edges since reset release; cycle alias is legal with x0
    repeat (7) @(posedge clk);
    read_chk("mcycle_n", 12'hB00, 32'd7);
    read_chk("cycle_alias", 12'hC00, 32'd8);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].en, vecs[i].f3, vecs[i].addr, vecs[i].idx, vecs[i].data);
      #1;
      check($sformatf("vec%0d_rd", i), rd_data, vecs[i].exp_rd);
      check($sformatf("vec%0d_ill", i), 32'(illegal), 32'(vecs[i].exp_ill));
    end
    @(negedge clk);
    idle();
    #1;
    check("mtvec_out", mtvec_out, 32'h1234_5674);
    check("mie_out_set", 32'(mie_out), 32'h1);

    // Trap with a simultaneous mscratch write: the write is dropped
    @(negedge clk);
    drive(1'b1, RW, 12'h340, 5'd1, 32'h1111_1111);
    trap_en = 1'b1; trap_pc = 32'h103; trap_cause = 32'd11; trap_val = 32'h55;
    @(negedge clk);
    trap_en = 1'b0;
    idle();
    #1;
    check("trap_mepc_out", mepc_out, 32'h100);
    check("trap_mie_out", 32'(mie_out), 32'h0);
    read_chk("trap_mstatus", 12'h300, 32'h0000_1880);
    read_chk("trap_mcause", 12'h342, 32'd11);
    read_chk("trap_mtval", 12'h343, 32'h55);
    read_chk("trap_mepc", 12'h341, 32'h100);
    read_chk("trap_mscratch", 12'h340, 32'hDEAD0000);

    @(negedge clk);
    idle();
    mret = 1'b1;
    @(negedge clk);
    mret = 1'b0;
    #1;
    check("mret_mie_out", 32'(mie_out), 32'h1);
    read_chk("mret_mstatus", 12'h300, 32'h0000_1888);

    // minstret: write beats increment, then increments by instret_inc
    @(negedge clk);
    drive(1'b1, RW, 12'hB02, 5'd1, 32'd10);
    instret_inc = 1'b1;
    @(negedge clk);
    idle();
    @(negedge clk);
    instret_inc = 1'b0;
    read_chk("instret", 12'hC02, 32'd11);
    read_chk("instreth", 12'hC82, 32'd0);
    @(negedge clk);
    drive(1'b1, RS, 12'hC82, 5'd1, 32'h1);
    #1;
    check("instreth_wr_ill", 32'(illegal), 32'h1);
    check("instreth_wr_rd", rd_data, 32'h0);

    // Carry from low to high half after a low-half write
    @(negedge clk);
    drive(1'b1, RW, 12'hB80, 5'd1, 32'h0);
    @(negedge clk);
    drive(1'b1, RW, 12'hB00, 5'd1, 32'hFFFF_FFFF);
    read_chk("carry_lo_pre", 12'hB00, 32'hFFFF_FFFF);
    read_chk("carry_hi", 12'hB80, 32'h1);

    // Full 64-bit wrap
    @(negedge clk);
    drive(1'b1, RW, 12'hB80, 5'd1, 32'hFFFF_FFFF);
    @(negedge clk);
    drive(1'b1, RW, 12'hB00, 5'd1, 32'hFFFF_FFFF);
    read_chk("wrap_lo_pre", 12'hB00, 32'hFFFF_FFFF);
    read_chk("wrap_hi", 12'hB80, 32'h0);

    // Asynchronous reset pulse between edges
    read_chk("pre_rst_mscratch", 12'h340, 32'hDEAD0000);
    #1 rst_n = 1'b0;
    #1;
    check("async_rd", rd_data, 32'h0);
    check("async_mtvec", mtvec_out, 32'h0);
    check("async_mepc", mepc_out, 32'h0);
    check("async_mie", 32'(mie_out), 32'h0);
    #1 rst_n = 1'b1;
    read_chk("post_rst_mcycle", 12'hB00, 32'd1);
    read_chk("post_rst_mtvec", 12'h305, 32'h0);

    @(negedge clk);
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR register file for the core: holds architectural CSRs and executes Zicsr read-modify-write (CSRRW/S/C and immediate forms).
- Maintains 64-bit cycle/instret counters and performs trap entry / MRET state updates.
- Sits beside the register file in execute: decode supplies funct3/address/operands, writeback takes rd_data, the trap/PC unit consumes mtvec_out/mepc_out.

Parameters:
- XLEN, 32, data width of CSRs and operands.
- CNT_W, 64, width of mcycle/minstret; upper half visible via *h CSRs.
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
- HART_ID, 0, value returned by mhartid.
- MISA_VAL, 32'h4000_0100, constant read value of misa (RV32I).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- csr_en  in  1  valid CSR instruction this cycle.
- funct3  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- csr_addr  in  12  CSR address.
- rs1_idx  in  5  rs1 field; zero-extended to XLEN as zimm for the immediate forms.
- rs1_data  in  XLEN  rs1 register value.
- rd_data  out  XLEN  old CSR value (combinational).
- illegal  out  1  illegal CSR access (combinational).
- instret_inc  in  1  one instruction retired this cycle.
- trap_en  in  1  take trap this cycle.
- trap_pc  in  XLEN  PC saved to mepc.
- trap_cause  in  XLEN  value for mcause.
- trap_val  in  XLEN  value for mtval.
- mret  in  1  execute MRET this cycle.
- mtvec_out  out  XLEN  registered mtvec.
- mepc_out  out  XLEN  registered mepc.
- mie_out  out  1  registered mstatus.MIE.

Behaviour:
- Reset (async, rst_n=0): all CSRs and counters 0, except mtvec=MTVEC_RESET. mtvec_out=MTVEC_RESET, mepc_out=0, mie_out=0. Reset asserted mid-operation clears state immediately; no pending write survives.
- Map:
  - mstatus 0x300: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - misa 0x301: reads MISA_VAL; writes ignored, not illegal.
  - mtvec 0x305 and mepc 0x341: bits[1:0] forced 0 on write.
  - mscratch 0x340, mcause 0x342, mtval 0x343: full XLEN, read/write.
  - mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82: read/write.
  - cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82: read-only aliases.
  - mhartid 0xF14: reads HART_ID, read-only.
- Source operand: src = rs1_data for funct3[2]=0; src = {27'b0, rs1_idx} for funct3[2]=1.
- New value: RW → src; RS → old|src; RC → old&~src.
- Write enable: csr_en and not illegal and (funct3[1:0]==01 or rs1_idx!=0). RS/RC with rs1_idx=0 is read-only and legal even on read-only CSRs.
- rd_data = current (pre-write) value whenever csr_en and not illegal; otherwise 0. The write commits at the next rising edge.
- illegal=1 when csr_en and any of:
  - address is unmapped;
  - funct3 is 000 or 100;
  - a write is enabled and csr_addr[11:10]==2'b11.
- When illegal=1 there is no state change.
- Counters: mcycle += 1 every cycle; minstret += instret_inc. A CSR write to either half takes precedence over the increment in that cycle and replaces only the addressed half; the other half holds its value, with no carry applied that cycle. Both counters wrap from 2^CNT_W-1 to 0.
- Trap (trap_en=1): mepc <= {trap_pc[XLEN-1:2],2'b00}, mcause <= trap_cause, mtval <= trap_val, MPIE <= MIE, MIE <= 0.
- Priority: trap_en over mret over CSR write. A CSR write in the same cycle as trap or mret is dropped (counters still increment).
- mret (no trap): MIE <= MPIE, MPIE <= 1.
- mtvec_out/mepc_out/mie_out reflect register state; an update is visible one cycle after the write edge.

Test Plan:
- Reset then CSRRS x0 on 0x305 → rd_data=MTVEC_RESET, illegal=0, no write; mcycle read at cycle N after reset returns N.
- CSRRW 0x340 with rs1_data=0xDEADBEEF, then CSRRC with rs1_data=0x0000FFFF → second rd_data=0xDEADBEEF, mscratch becomes 0xDEAD0000.
- CSRRWI to 0xC00 with rs1_idx=5 → illegal=1, cycle unchanged. CSRRS x0 on 0xC00 → legal. Access to 0x7FF → illegal=1, rd_data=0.
- CSRRSI 0x300 with imm=8 (MIE=1), then trap_en with trap_pc=0x103, cause=11 → mepc=0x100, mcause=11, MIE=0, MPIE=1. Then mret → MIE=1, MPIE=1.
- Write mcycle=0xFFFF_FFFF with mcycleh=0 → next cycle mcycleh=1, mcycle=0. trap_en and CSRRW mscratch in the same cycle → mscratch unchanged.
- Pulse rst_n low between clock edges mid-sequence → all outputs return to reset values immediately, without waiting for a clock edge.
